// File: rtl/raster_pixel_source.sv
// Column-major raster pixel generator for the ellipse_renderer pipeline (y fast, x slow).
// Optional macro PIXSRC_PATTERN_EN replaces the flat colour with an x/y gradient test pattern.
module raster_pixel_source #(
  parameter int CONTINUOUS  = 0,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   stall,
  input  logic [10:0]            width_m1,
  input  logic [11:0]            height_m1,
  input  logic [7:0]             r_bg,
  input  logic [7:0]             g_bg,
  input  logic [7:0]             b_bg,
  output logic signed [10:0]     x,
  output logic signed [11:0]     y,
  output logic [7:0]             r,
  output logic [7:0]             g,
  output logic [7:0]             b,
  output logic                   valid,
  output logic                   sof,
  output logic                   eol,
  output logic                   eof,
  output logic                   busy,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [10:0]            x_q, x_d, w_q, w_d;
  logic [11:0]            y_q, y_d, h_q, h_d;
  logic [7:0]             rbg_q, rbg_d, gbg_q, gbg_d, bbg_q, bbg_d;
  logic                   stop_q, stop_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;

  logic run, last_x, last_y, keep_running;

  assign run    = (state_q == ST_RUN);
  assign last_x = (x_q == w_q);
  assign last_y = (y_q == h_q);
  // A stop arriving on the eof cycle itself still ends the current frame.
  assign keep_running = (CONTINUOUS != 0) && !stop_q && !stop;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    rbg_d   = rbg_q;
    gbg_d   = gbg_q;
    bbg_d   = bbg_q;
    stop_d  = stop_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d     = width_m1;
          h_d     = height_m1;
          rbg_d   = r_bg;
          gbg_d   = g_bg;
          bbg_d   = b_bg;
          x_d     = '0;
          y_d     = '0;
          stop_d  = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if ((CONTINUOUS != 0) && stop) stop_d = 1'b1;
        if (!stall) begin
          if (!last_y) begin
            y_d = y_q + 12'd1;
          end else begin
            y_d = '0;
            if (!last_x) begin
              x_d = x_q + 11'd1;
            end else begin
              x_d    = '0;
              fcnt_d = fcnt_q + FRAME_CNT_W'(1);
              if (!keep_running) begin
                stop_d  = 1'b0;
                state_d = ST_DONE;
              end
            end
          end
        end
      end
      ST_DONE: begin
        x_d     = '0;
        y_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      rbg_q   <= '0;
      gbg_q   <= '0;
      bbg_q   <= '0;
      stop_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      rbg_q   <= rbg_d;
      gbg_q   <= gbg_d;
      bbg_q   <= bbg_d;
      stop_q  <= stop_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign x           = $signed(x_q);
  assign y           = $signed(y_q);
  assign valid       = run;
  assign busy        = run;
  assign done        = (state_q == ST_DONE);
  assign sof         = run && (x_q == 11'd0) && (y_q == 12'd0);
  assign eol         = run && last_y;
  assign eof         = run && last_y && last_x;
  assign frame_count = fcnt_q;

`ifdef PIXSRC_PATTERN_EN
  logic unused_bg;
  assign unused_bg = ^{gbg_q, bbg_q};
  assign r = run ? x_q[7:0] : 8'd0;
  assign g = run ? y_q[7:0] : 8'd0;
  assign b = run ? (rbg_q ^ x_q[7:0] ^ y_q[7:0]) : 8'd0;
`else
  assign r = run ? rbg_q : 8'd0;
  assign g = run ? gbg_q : 8'd0;
  assign b = run ? bbg_q : 8'd0;
`endif

endmodule

// File: tb/tb_raster_pixel_source.sv
// Randomized bench for raster_pixel_source: one single-frame instance and one continuous
// instance (narrow frame counter to exercise wrap), both checked against a scan-order model.
module tb_raster_pixel_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst[2], start[2], stop[2], stall[2];
  logic [10:0]       width_m1[2];
  logic [11:0]       height_m1[2];
  logic [7:0]        r_bg[2], g_bg[2], b_bg[2];
  logic signed [10:0] x[2];
  logic signed [11:0] y[2];
  logic [7:0]        r[2], g[2], b[2];
  logic              valid[2], sof[2], eol[2], eof[2], busy[2], done[2];
  logic [15:0]       fcnt0;
  logic [1:0]        fcnt1;

  int checks = 0;
  int errors = 0;
  int fc[2];

  raster_pixel_source #(.CONTINUOUS(0), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst(rst[0]), .start(start[0]), .stop(stop[0]), .stall(stall[0]),
    .width_m1(width_m1[0]), .height_m1(height_m1[0]),
    .r_bg(r_bg[0]), .g_bg(g_bg[0]), .b_bg(b_bg[0]),
    .x(x[0]), .y(y[0]), .r(r[0]), .g(g[0]), .b(b[0]),
    .valid(valid[0]), .sof(sof[0]), .eol(eol[0]), .eof(eof[0]),
    .busy(busy[0]), .done(done[0]), .frame_count(fcnt0)
  );

  raster_pixel_source #(.CONTINUOUS(1), .FRAME_CNT_W(2)) dut_c (
    .clk(clk), .rst(rst[1]), .start(start[1]), .stop(stop[1]), .stall(stall[1]),
    .width_m1(width_m1[1]), .height_m1(height_m1[1]),
    .r_bg(r_bg[1]), .g_bg(g_bg[1]), .b_bg(b_bg[1]),
    .x(x[1]), .y(y[1]), .r(r[1]), .g(g[1]), .b(b[1]),
    .valid(valid[1]), .sof(sof[1]), .eol(eol[1]), .eof(eof[1]),
    .busy(busy[1]), .done(done[1]), .frame_count(fcnt1)
  );

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] obs(input int d);
    logic [15:0] f;
    f = (d == 0) ? fcnt0 : {14'd0, fcnt1};
    return {11'd0, valid[d], busy[d], done[d], sof[d], eol[d], eof[d],
            x[d], y[d], r[d], g[d], b[d], f};
  endfunction

  // Expected output word for a pixel position (v=1), the done cycle (dn=1) or idle.
  function automatic logic [79:0] expv(input int d, input bit v, input bit dn,
                                       input int xx, input int yy, input int w, input int h,
                                       input logic [7:0] cr, input logic [7:0] cg,
                                       input logic [7:0] cb);
    logic [7:0] er, eg, eb;
    logic [15:0] f;
    logic [31:0] xv, yv;
    xv = xx;
    yv = yy;
    er = 8'd0; eg = 8'd0; eb = 8'd0;
    if (v) begin
`ifdef PIXSRC_PATTERN_EN
      er = xv[7:0];
      eg = yv[7:0];
      eb = cr ^ xv[7:0] ^ yv[7:0];
`else
      er = cr; eg = cg; eb = cb;
`endif
    end
    f = 16'(fc[d] & ((d == 0) ? 32'hFFFF : 32'h3));
    return {11'd0, v, v, dn, v && xx == 0 && yy == 0, v && yy == h, v && yy == h && xx == w,
            xv[10:0], yv[11:0], er, eg, eb, f};
  endfunction

  task automatic do_start(input int d, input int w, input int h,
                          input logic [7:0] cr, input logic [7:0] cg, input logic [7:0] cb);
    width_m1[d] = 11'(w); height_m1[d] = 12'(h);
    r_bg[d] = cr; g_bg[d] = cg; b_bg[d] = cb;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    // Scramble inputs: the frame must use the values latched at start.
    width_m1[d] = 11'($urandom); height_m1[d] = 12'($urandom);
    r_bg[d] = 8'($urandom); g_bg[d] = 8'($urandom); b_bg[d] = 8'($urandom);
  endtask

  task automatic run_scan(input int d, input int w, input int h, input int nfr,
                          input int stop_pos, input int stall_pct, input int stall_at,
                          input int start_pos, input logic [7:0] cr, input logic [7:0] cg,
                          input logic [7:0] cb);
    int npix;
    int nst;
    npix = (w + 1) * (h + 1);
    do_start(d, w, h, cr, cg, cb);
    for (int f = 0; f < nfr; f++) begin
      for (int idx = 0; idx < npix; idx++) begin
        if (idx == stall_at) nst = 3;
        else nst = ($urandom_range(99) < stall_pct) ? int'($urandom_range(3, 1)) : 0;
        for (int s = 0; s <= nst; s++) begin
          check_val("pix", obs(d), expv(d, 1'b1, 1'b0, idx / (h + 1), idx % (h + 1), w, h, cr, cg, cb));
          stall[d] = (s < nst);
          stop[d]  = (s == nst) && (f == nfr - 1) && (idx == stop_pos);
          start[d] = (idx == start_pos);
          @(negedge clk);
        end
        if (idx == npix - 1) fc[d]++;
      end
    end
    stall[d] = 1'b0; stop[d] = 1'b0;
    check_val("done", obs(d), expv(d, 1'b0, 1'b1, 0, 0, w, h, cr, cg, cb));
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    check_val("idle", obs(d), expv(d, 1'b0, 1'b0, 0, 0, w, h, cr, cg, cb));
    @(negedge clk);
    check_val("idle2", obs(d), expv(d, 1'b0, 1'b0, 0, 0, w, h, cr, cg, cb));
  endtask

  task automatic run_reset(input int d, input int w, input int h, input int rst_pos,
                           input bit with_start);
    logic [7:0] cr, cg, cb;
    cr = 8'($urandom); cg = 8'($urandom); cb = 8'($urandom);
    do_start(d, w, h, cr, cg, cb);
    for (int idx = 0; idx < rst_pos; idx++) begin
      check_val("pre_rst", obs(d), expv(d, 1'b1, 1'b0, idx / (h + 1), idx % (h + 1), w, h, cr, cg, cb));
      @(negedge clk);
    end
    rst[d] = 1'b1;
    start[d] = with_start;
    @(negedge clk);
    rst[d] = 1'b0;
    start[d] = 1'b0;
    fc[d] = 0;
    check_val("post_rst", obs(d), expv(d, 1'b0, 1'b0, 0, 0, w, h, cr, cg, cb));
    @(negedge clk);
    check_val("post_rst2", obs(d), expv(d, 1'b0, 1'b0, 0, 0, w, h, cr, cg, cb));
  endtask

  initial begin
    int w, h, nfr;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; stop[d] = 1'b0; stall[d] = 1'b0;
      width_m1[d] = '0; height_m1[d] = '0; r_bg[d] = '0; g_bg[d] = '0; b_bg[d] = '0;
      fc[d] = 0;
    end
    start[0] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val("reset", obs(d), expv(d, 1'b0, 1'b0, 0, 0, 0, 0, 8'd0, 8'd0, 8'd0));
      rst[d] = 1'b0;
    end
    start[0] = 1'b0;
    @(negedge clk);

    // 32x32 single frame with a 3-cycle stall at (2,5) and a stray start/stop mid-frame.
    run_scan(0, 31, 31, 1, 100, 0, 2 * 32 + 5, 50, 8'h10, 8'h20, 8'h30);
    run_scan(0, 0, 0, 1, 0, 0, -1, -1, 8'hA5, 8'h5A, 8'hC3);
    for (int t = 0; t < 6; t++) begin
      w = $urandom_range(7); h = $urandom_range(7);
      run_scan(0, w, h, 1, $urandom_range((w + 1) * (h + 1) - 1), 30, -1,
               $urandom_range((w + 1) * (h + 1) - 1), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // Continuous: 4x3 frame, stop at (1,0) of frame 2.
    run_scan(1, 3, 2, 2, 1 * 3 + 0, 0, -1, 5, 8'h11, 8'h22, 8'h33);
    run_scan(1, 0, 0, 3, 0, 0, -1, -1, 8'h01, 8'h02, 8'h03);
    for (int t = 0; t < 6; t++) begin
      w = $urandom_range(5); h = $urandom_range(5);
      nfr = $urandom_range(5, 1);
      run_scan(1, w, h, nfr, $urandom_range((w + 1) * (h + 1) - 1), 25, -1,
               $urandom_range((w + 1) * (h + 1) - 1), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    run_reset(0, 9, 9, 5 * 10 + 7, 1'b0);
    run_scan(0, 2, 3, 1, 0, 20, -1, -1, 8'h77, 8'h88, 8'h99);
    run_reset(1, 4, 4, 13, 1'b1);
    run_scan(1, 1, 2, 2, 4, 20, -1, -1, 8'h44, 8'h55, 8'h66);

`ifdef PIXSRC_PATTERN_EN
    // Directed pattern pixel (3,5) with r_bg=0xFF.
    do_start(0, 7, 7, 8'hFF, 8'h00, 8'h00);
    for (int idx = 0; idx < 3 * 8 + 5; idx++) @(negedge clk);
    check_val("pattern", {56'd0, r[0], g[0], b[0]}, {56'd0, 8'h03, 8'h05, 8'hF9});
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/raster_pixel_source.md
Name: raster_pixel_source

Overview:
- Synthesizable pixel-stream generator for the ellipse_renderer pipeline, replacing the hand-written stimulus loop.
- Emits one (x, y, r, g, b) pixel per clock over a programmable frame. Scan is column-major: y is the fast index, x the slow one. Widths match the renderer inputs.
- Provides start/stop control, a stall input, and frame framing flags.
- Downstream blocks use the flags to know when a full screen has been covered.

Parameters:
- CONTINUOUS, 0: 1 = restart the frame automatically after the last pixel until `stop`; 0 = one frame per `start`.
- FRAME_CNT_W, 16: width of `frame_count`.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin scan; sampled only in IDLE
- stop  in  1  finish current frame then halt; CONTINUOUS mode only, sticky until DONE
- stall  in  1  freeze stream; all outputs hold
- width_m1  in  11  last x index (frame width − 1); latched on start
- height_m1  in  12  last y index (frame height − 1); latched on start
- r_bg, g_bg, b_bg  in  8 each  pixel colour; latched on start
- x  out  11 signed  current column
- y  out  12 signed  current row
- r, g, b  out  8 each  pixel colour
- valid  out  1  pixel on x/y/r/g/b is valid
- sof  out  1  first pixel of frame (x=0, y=0)
- eol  out  1  last pixel of a column (y = height_m1)
- eof  out  1  last pixel of frame (x = width_m1, y = height_m1)
- busy  out  1  state is RUN
- done  out  1  one-cycle pulse after the final frame is accepted
- frame_count  out  FRAME_CNT_W  completed frames since reset; wraps to 0

Behaviour:
- Reset (rst=1 at a clock edge, including mid-frame):
  - state goes to IDLE.
  - x, y, r, g, b, valid, sof, eol, eof, busy, done all go to 0; frame_count goes to 0.
  - Pending stop is cleared; latched dimensions and colours are cleared.
- States:
  - IDLE:
    - outputs 0.
    - start=1 latches width_m1, height_m1 and colours, then goes to RUN.
    - First pixel (0,0) appears with valid=1, sof=1 on the cycle after start is sampled. Latency is 1 clock.
  - RUN:
    - valid=1, busy=1.
    - Each cycle with stall=0 advances: if y < height_m1 then y+1; else y=0 and x+1.
    - Unsigned compares on the latched values; x and y never go negative.
    - stall=1 holds every output and internal register unchanged. stall has no effect in IDLE or DONE.
  - Last pixel (eof=1) accepted (stall=0):
    - frame_count increments, wrapping from all-ones to 0.
    - If CONTINUOUS=1 and no stop is pending: next cycle x=0, y=0, sof=1. There is no bubble.
    - Otherwise go to DONE.
  - DONE:
    - valid=0, busy=0, done=1 for exactly one cycle; x/y/rgb return to 0.
    - Then IDLE.
- Flags:
  - sof, eol and eof are combinational decodes of the registered x/y versus the latched limits, qualified by valid.
  - On a 1×1 frame (width_m1=0, height_m1=0), sof, eol and eof are all 1 on the single pixel.
- start in RUN or DONE is ignored. Dimensions and colours cannot change mid-frame.
- stop:
  - With CONTINUOUS=0, stop is ignored.
  - With CONTINUOUS=1, stop is latched on any RUN cycle. The frame completes and done pulses.
  - stop on the eof cycle applies to the current frame.
- Simultaneous rst and start: rst wins.

Optional Feature:
- Macro: PIXSRC_PATTERN_EN.
- Defined:
  - r = x[7:0], g = y[7:0], b = r_bg XOR (x[7:0] ^ y[7:0]).
  - This gives a gradient test pattern for visual checking of renderer output.
  - Colours are computed from the registered x/y, with the same timing and stall hold as the coordinates.
  - g_bg and b_bg are unused.
- Undefined: r/g/b equal the latched r_bg/g_bg/b_bg throughout RUN.

Test Plan:
1. Single frame:
   - Stimulus: rst then release; start with width_m1=31, height_m1=31, colour 0x10/0x20/0x30.
   - Response: 1024 valid pixels in order (0,0),(0,1)…(0,31),(1,0)…(31,31). sof only on the first, eol every 32nd, eof on the last. done pulses the cycle after. frame_count=1.
2. Stall:
   - Stimulus: stall=1 for 3 cycles while at (2,5).
   - Response: outputs held at (2,5) for 4 cycles total; the next pixel is (2,6). Total valid-and-not-stall count stays 1024.
3. Continuous + stop:
   - Stimulus: CONTINUOUS=1, 4×3 frame (width_m1=3, height_m1=2); stop asserted during frame 2 at (1,0).
   - Response: frame 1 eof is followed immediately by (0,0) with sof. Frame 2 completes to (3,2); done pulses; frame_count=2.
4. Degenerate:
   - Stimulus: width_m1=0, height_m1=0.
   - Response: one pixel with sof=eol=eof=1, then done.
5. Reset mid-frame and start while busy:
   - Stimulus: rst at (5,7); separately, start pulsed in RUN.
   - Response: after rst, all outputs 0 and frame_count=0 on the next cycle. The start in RUN causes no restart.
6. Pattern build:
   - Stimulus: build with PIXSRC_PATTERN_EN, r_bg=0xFF; observe pixel (3,5).
   - Response: r=0x03, g=0x05, b=0xF9.
